input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Front end of the ALU board top: sits between board push-buttons/switches and the operand/opcode
//  latch stage. Synchronises raw buttons and switches to the clock and debounces each button.
//  Each confirmed press becomes a single-cycle one-hot strobe with a qualifying valid.
//  Switch data is captured and held alongside each strobe.
// PARAMETERS
//  NB_INPUT_SELECT  3          number of push-buttons; bit0=DATA_A, bit1=DATA_B, bit2=OP_CODE
//  NB_DATA_IN       8          switch bus width
//  DEBOUNCE_CYCLES  1000000    consecutive stable cycles to confirm press/release (>=2; 10 ms @100 MHz)
//  NB_DEB_CNT       $clog2(DEBOUNCE_CYCLES)  debounce counter width (localparam)
// PORTS
//  clock      in   1                clock; every flop rises on posedge
//  i_rst      in   1                reset, asynchronous, active-high
//  i_btn_raw  in   NB_INPUT_SELECT  raw asynchronous buttons, 1 = pressed
//  i_sw_raw   in   NB_DATA_IN       raw asynchronous switches
//  o_btn      out  NB_INPUT_SELECT  one-hot press strobe, high one cycle, zero otherwise
//  o_sw_data  out  NB_DATA_IN       synchronised switch value captured at the last strobe
//  o_valid    out  1                high exactly in cycles where o_btn != 0
// BEHAVIOUR
//  - Reset: all sync flops, counters, o_btn, o_sw_data, o_valid = 0; every button FSM = IDLE.
//  - Sync: 2-flop synchroniser per button bit and per switch bit. FSMs see only stage-2 values (btn_s, sw_s).
//  - Per-button FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Each button has its own NB_DEB_CNT counter.
//    IDLE: btn_s=1 -> PRESS_WAIT, cnt=1.
//    PRESS_WAIT: btn_s=0 -> IDLE, cnt=0; btn_s=1 with cnt=DEBOUNCE_CYCLES-1 -> PRESSED, raise press_evt
//      for 1 cycle; otherwise cnt++.
//    PRESSED: btn_s=0 -> RELEASE_WAIT, cnt=1; holding produces no further events.
//    RELEASE_WAIT: btn_s=1 -> PRESSED, cnt=0; btn_s=0 with cnt=DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt++.
//    No release event is produced.
//  - Counter never wraps: cnt is at most DEBOUNCE_CYCLES-1 and is cleared on every state change.
//  - Output stage (registered, 1 cycle after press_evt):
//    - o_btn = lowest-index set bit of press_evt vector (priority matches downstream DATA_A>DATA_B>OP_CODE).
//    - o_valid = |press_evt; o_sw_data <= sw_s in that same cycle.
//    - Otherwise o_btn=0 and o_valid=0; o_sw_data holds.
//  - Latency: clock edge first sampling i_btn_raw=1 (held stable) -> o_valid high after edge DEBOUNCE_CYCLES+3.
//  - Simultaneous confirmation: only the lowest index is strobed. Higher-index events are dropped,
//    not queued; their FSMs still go to PRESSED and need a release/re-press to fire.
//  - Glitch shorter than DEBOUNCE_CYCLES: no strobe, FSM returns to IDLE.
//  - Button held across reset release: FSM starts in IDLE, so one strobe follows after the normal latency.
//  - Reset mid-debounce: immediately clears state and outputs; no strobe from the aborted press.
//  - o_sw_data is stable whenever o_valid=0; switch changes between strobes are invisible.
// TESTING (DEBOUNCE_CYCLES=4)
//  1 sw=0x5A, btn_raw=001 held 20 cycles -> o_valid=1, o_btn=001, o_sw_data=0x5A for exactly 1 cycle
//    at edge 7; zero afterwards.
//  2 btn_raw[1] high 3 cycles, low, repeated 5 times -> o_valid never asserts. Then held 10 cycles
//    -> single o_btn=010.
//  3 btn_raw[2] held 100 cycles -> one strobe; release 10 cycles, press again -> second strobe o_btn=100.
//    1-cycle release glitch mid-hold -> no extra strobe.
//  4 btn_raw=101 rising same edge -> one strobe o_btn=001 only. Release both, press 100 -> o_btn=100.
//  5 btn_raw=001 held, i_rst pulsed at edge 4, btn released before reset drops -> no strobe;
//    all outputs 0 during and after reset.
//  6 strobe with sw=0x3C, then sw->0xFF without a press -> o_sw_data stays 0x3C.
//    Next btn_raw=010 press -> o_sw_data=0xFF with the strobe.

Source files
------------

// File: rtl/input_conditioner.sv
// ----------------------------------------------------------------------------
// input_conditioner
//   Board front end for the ALU top. Brings raw push-buttons and switches into
//   the clock domain, debounces every button independently and turns each
//   confirmed press into a single-cycle one-hot strobe. The synchronised
//   switch value is captured alongside the strobe and held until the next one.
// ----------------------------------------------------------------------------
module input_conditioner #(
  parameter int NB_INPUT_SELECT = 3,        // bit0=DATA_A, bit1=DATA_B, bit2=OP_CODE
  parameter int NB_DATA_IN      = 8,        // switch bus width
  parameter int DEBOUNCE_CYCLES = 1000000   // stable samples needed to confirm (>=2)
) (
  input  logic                       clock,
  input  logic                       i_rst,
  input  logic [NB_INPUT_SELECT-1:0] i_btn_raw,
  input  logic [NB_DATA_IN-1:0]      i_sw_raw,
  output logic [NB_INPUT_SELECT-1:0] o_btn,
  output logic [NB_DATA_IN-1:0]      o_sw_data,
  output logic                       o_valid
);

  localparam int NB_DEB_CNT = $clog2(DEBOUNCE_CYCLES);

  // Counter constants sized to the counter so every compare/assign is width-exact.
  localparam logic [NB_DEB_CNT-1:0] CNT_ZERO = '0;
  localparam logic [NB_DEB_CNT-1:0] CNT_ONE  = NB_DEB_CNT'(1);
  localparam logic [NB_DEB_CNT-1:0] CNT_LAST = NB_DEB_CNT'(DEBOUNCE_CYCLES - 1);

  localparam logic [NB_INPUT_SELECT-1:0] SEL_ZERO = '0;
  localparam logic [NB_INPUT_SELECT-1:0] SEL_ONE  = NB_INPUT_SELECT'(1);
  localparam logic [NB_DATA_IN-1:0]      SW_ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronisers. Only the second stage (btn_s / sw_s) is used by
  // downstream logic; the first stage may go metastable.
  // --------------------------------------------------------------------------
  logic [NB_INPUT_SELECT-1:0] btn_meta;
  logic [NB_INPUT_SELECT-1:0] btn_s;
  logic [NB_DATA_IN-1:0]      sw_meta;
  logic [NB_DATA_IN-1:0]      sw_s;

  // Synchronise raw buttons and switches into the clock domain.
  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      btn_meta <= SEL_ZERO;
      btn_s    <= SEL_ZERO;
      sw_meta  <= SW_ZERO;
      sw_s     <= SW_ZERO;
    end else begin
      btn_meta <= i_btn_raw;
      btn_s    <= btn_meta;
      sw_meta  <= i_sw_raw;
      sw_s     <= sw_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Per-button debounce FSM. The counter tracks how many consecutive samples
  // have disagreed with the confirmed level; it is cleared on every state
  // change and never exceeds CNT_LAST, so it cannot wrap.
  // press_evt is registered so a confirmed press appears one cycle after the
  // confirming sample, and the output stage adds one more register.
  // --------------------------------------------------------------------------
  logic [NB_INPUT_SELECT-1:0] press_evt;

  for (genvar g = 0; g < NB_INPUT_SELECT; g++) begin : g_deb
    deb_state_t            state;
    deb_state_t            state_next;
    logic [NB_DEB_CNT-1:0] cnt;
    logic [NB_DEB_CNT-1:0] cnt_next;
    logic                  press_set;
    logic                  press_q;

    // State, counter and press-event registers for this button.
    always_ff @(posedge clock or posedge i_rst) begin
      if (i_rst) begin
        state   <= IDLE;
        cnt     <= CNT_ZERO;
        press_q <= 1'b0;
      end else begin
        state   <= state_next;
        cnt     <= cnt_next;
        press_q <= press_set;
      end
    end

    // Next-state and counter update from the synchronised button level.
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
        IDLE: begin
          if (btn_s[g]) begin
            state_next = PRESS_WAIT;
            cnt_next   = CNT_ONE;
          end else begin
            state_next = IDLE;
            cnt_next   = CNT_ZERO;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s[g]) begin
            state_next = IDLE;
            cnt_next   = CNT_ZERO;
          end else if (cnt == CNT_LAST) begin
            state_next = PRESSED;
            cnt_next   = CNT_ZERO;
          end else begin
            state_next = PRESS_WAIT;
            cnt_next   = cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!btn_s[g]) begin
            state_next = RELEASE_WAIT;
            cnt_next   = CNT_ONE;
          end else begin
            state_next = PRESSED;
            cnt_next   = CNT_ZERO;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s[g]) begin
            state_next = PRESSED;
            cnt_next   = CNT_ZERO;
          end else if (cnt == CNT_LAST) begin
            state_next = IDLE;
            cnt_next   = CNT_ZERO;
          end else begin
            state_next = RELEASE_WAIT;
            cnt_next   = cnt + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = CNT_ZERO;
        end
      endcase
    end

    // Press event fires only on the PRESS_WAIT -> PRESSED transition; releases are silent.
    always_comb begin
      if ((state == PRESS_WAIT) && btn_s[g] && (cnt == CNT_LAST)) begin
        press_set = 1'b1;
      end else begin
        press_set = 1'b0;
      end
    end

    assign press_evt[g] = press_q;
  end

  // --------------------------------------------------------------------------
  // Output stage. Only the lowest-index event is forwarded; simultaneous
  // higher-index events are dropped, matching the downstream priority
  // DATA_A > DATA_B > OP_CODE.
  // --------------------------------------------------------------------------
  logic [NB_INPUT_SELECT-1:0] press_first;

  // Isolate the lowest set bit of the event vector (x & -x).
  always_comb begin
    press_first = press_evt & (~press_evt + SEL_ONE);
  end

  // Register the strobe and capture the switch value only when a strobe fires.
  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      o_btn     <= SEL_ZERO;
      o_valid   <= 1'b0;
      o_sw_data <= SW_ZERO;
    end else begin
      o_btn   <= press_first;
      o_valid <= |press_evt;
      if (|press_evt) begin
        o_sw_data <= sw_s;
      end else begin
        o_sw_data <= o_sw_data;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// ----------------------------------------------------------------------------
// tb_input_conditioner
//   Scoreboard bench. A reference model reads the applied inputs every edge,
//   tracks per button the confirmed level and the run length of disagreeing
//   samples, and queues the strobe it expects (edge, one-hot, switch data).
//   A separate monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int NB  = 3;
  localparam int NSW = 8;
  localparam int D   = 4;

  logic           clock;
  logic           i_rst;
  logic [NB-1:0]  i_btn_raw;
  logic [NSW-1:0] i_sw_raw;
  logic [NB-1:0]  o_btn;
  logic [NSW-1:0] o_sw_data;
  logic           o_valid;

  input_conditioner #(
    .NB_INPUT_SELECT(NB),
    .NB_DATA_IN     (NSW),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock    (clock),
    .i_rst    (i_rst),
    .i_btn_raw(i_btn_raw),
    .i_sw_raw (i_sw_raw),
    .o_btn    (o_btn),
    .o_sw_data(o_sw_data),
    .o_valid  (o_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int             at_edge;
    logic [NB-1:0]  btn;
    logic [NSW-1:0] sw;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   edge_cnt = 0;

  // Observations gathered by the monitor for directed end-of-test checks.
  int             strobes   = 0;
  logic [NB-1:0]  last_btn  = '0;
  logic [NSW-1:0] last_sw   = '0;
  int             last_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference model: a press is confirmed on the D-th consecutive sample that
  // disagrees with the confirmed level. The sample applied at edge e is seen by
  // the debouncer two edges later and strobes one edge after that (e+3); the
  // captured switch value is the one applied at edge e+1, so the model works
  // one edge behind the inputs.
  initial begin
    bit            conf [NB];
    int            run  [NB];
    logic [NB-1:0] prev_btn;
    int            prev_edge;
    bit            have_prev;
    bit            fired;
    exp_t          e;
    have_prev = 1'b0;
    prev_btn  = '0;
    prev_edge = 0;
    for (int i = 0; i < NB; i++) begin
      conf[i] = 1'b0;
      run[i]  = 0;
    end
    forever begin
      @(posedge clock);
      edge_cnt = edge_cnt + 1;
      if (i_rst) begin
        for (int i = 0; i < NB; i++) begin
          conf[i] = 1'b0;
          run[i]  = 0;
        end
        have_prev = 1'b0;
      end else begin
        if (have_prev) begin
          fired = 1'b0;
          for (int i = 0; i < NB; i++) begin
            if (prev_btn[i] == conf[i]) begin
              run[i] = 0;
            end else begin
              run[i] = run[i] + 1;
              if (run[i] == D) begin
                conf[i] = prev_btn[i];
                run[i]  = 0;
                if (prev_btn[i] && !fired) begin
                  fired     = 1'b1;
                  e.at_edge = prev_edge + 3;
                  e.btn     = NB'(1) << i;
                  e.sw      = i_sw_raw;
                  exp_q.push_back(e);
                end
              end
            end
          end
        end
        prev_btn  = i_btn_raw;
        prev_edge = edge_cnt;
        have_prev = 1'b1;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard on every falling edge.
  initial begin
    exp_t           e;
    logic [NSW-1:0] exp_sw;
    exp_sw = '0;
    forever begin
      @(negedge clock);
      if (i_rst) begin
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_btn", 32'(o_btn), 32'd0);
        check("rst_sw", 32'(o_sw_data), 32'd0);
        exp_q.delete();
        exp_sw = '0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].at_edge < edge_cnt) begin
          e = exp_q.pop_front();
          check("missing_strobe", 32'(edge_cnt), 32'(e.at_edge));
        end
        check("valid_vs_btn", 32'(o_valid), 32'(o_btn != '0));
        check("btn_onehot0", 32'($onehot0(o_btn)), 32'd1);
        if (o_valid) begin
          strobes++;
          last_btn  = o_btn;
          last_sw   = o_sw_data;
          last_edge = edge_cnt;
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'(o_btn), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("strobe_edge", 32'(edge_cnt), 32'(e.at_edge));
            check("strobe_btn", 32'(o_btn), 32'(e.btn));
            check("strobe_sw", 32'(o_sw_data), 32'(e.sw));
            exp_sw = e.sw;
          end
        end else begin
          check("sw_hold", 32'(o_sw_data), 32'(exp_sw));
        end
      end
    end
  end

  task automatic hold(input logic [NB-1:0] b, input logic [NSW-1:0] s, input int n);
    i_btn_raw = b;
    i_sw_raw  = s;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Stimulus: directed scenarios followed by randomized bursts.
  initial begin
    int s0;
    int t0;
    i_rst     = 1'b1;
    i_btn_raw = '0;
    i_sw_raw  = '0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    i_rst = 1'b0;
    hold(3'b000, 8'h00, 5);

    // 1: single press, strobe exactly D+3 edges after first sample.
    s0 = strobes;
    t0 = edge_cnt;
    hold(3'b001, 8'h5A, 20);
    hold(3'b000, 8'h5A, 10);
    check("t1_count", 32'(strobes - s0), 32'd1);
    check("t1_edge", 32'(last_edge - t0), 32'd7);
    check("t1_btn", 32'(last_btn), 32'h1);
    check("t1_sw", 32'(last_sw), 32'h5A);

    // 2: short glitches are filtered, then a real press.
    s0 = strobes;
    for (int k = 0; k < 5; k++) begin
      hold(3'b010, 8'h11, 3);
      hold(3'b000, 8'h11, 3);
    end
    check("t2_glitch_count", 32'(strobes - s0), 32'd0);
    hold(3'b010, 8'h22, 10);
    hold(3'b000, 8'h22, 10);
    check("t2_count", 32'(strobes - s0), 32'd1);
    check("t2_btn", 32'(last_btn), 32'h2);

    // 3: long hold, re-press, and a 1-cycle release glitch mid-hold.
    s0 = strobes;
    hold(3'b100, 8'h33, 100);
    hold(3'b000, 8'h33, 10);
    hold(3'b100, 8'h44, 20);
    hold(3'b000, 8'h44, 1);
    hold(3'b100, 8'h44, 20);
    hold(3'b000, 8'h44, 10);
    check("t3_count", 32'(strobes - s0), 32'd2);
    check("t3_btn", 32'(last_btn), 32'h4);

    // 4: simultaneous confirmation strobes only the lowest index.
    s0 = strobes;
    hold(3'b101, 8'h55, 20);
    hold(3'b000, 8'h55, 10);
    check("t4_first_count", 32'(strobes - s0), 32'd1);
    check("t4_first_btn", 32'(last_btn), 32'h1);
    hold(3'b100, 8'h66, 20);
    hold(3'b000, 8'h66, 10);
    check("t4_count", 32'(strobes - s0), 32'd2);
    check("t4_btn", 32'(last_btn), 32'h4);

    // 5: reset mid-debounce aborts the press.
    s0 = strobes;
    hold(3'b001, 8'h77, 3);
    i_rst = 1'b1;
    hold(3'b001, 8'h77, 1);
    hold(3'b000, 8'h77, 2);
    i_rst = 1'b0;
    hold(3'b000, 8'h77, 12);
    check("t5_count", 32'(strobes - s0), 32'd0);
    check("t5_sw_cleared", 32'(o_sw_data), 32'd0);

    // 6: switch data captured only with a strobe.
    s0 = strobes;
    hold(3'b001, 8'h3C, 10);
    hold(3'b000, 8'h3C, 10);
    hold(3'b000, 8'hFF, 10);
    check("t6_sw_held", 32'(o_sw_data), 32'h3C);
    hold(3'b010, 8'hFF, 10);
    hold(3'b000, 8'hFF, 10);
    check("t6_count", 32'(strobes - s0), 32'd2);
    check("t6_sw", 32'(last_sw), 32'hFF);

    // Randomized bursts with occasional resets.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 14) == 0) begin
        i_rst = 1'b1;
        hold(NB'($urandom_range(0, 7)), NSW'($urandom), 2);
        i_rst = 1'b0;
      end
      hold(NB'($urandom_range(0, 7)), NSW'($urandom), $urandom_range(1, 9));
    end

    hold(3'b000, 8'h00, 20);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
